// File: rtl/fuji_ps2_pkg.sv
// Shared types and constants for the FujiIIe PS/2 keyboard input path.
package fuji_ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchronizer followed by a glitch filter that accepts a new level
// only after FILTER_CYCLES consecutive equal synchronized samples.
module ps2_input_filter #(
    parameter int unsigned FILTER_CYCLES = 8,
    parameter logic        RESET_LEVEL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o
);

    localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= {2{RESET_LEVEL}};
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host frame receiver with prefix folding and a small
// first-word fall-through event FIFO using valid/ready output handshake.
module ps2_keyboard_receiver
    import fuji_ps2_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk_100M,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_release,
    output logic       frame_error,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_filt;
    logic data_filt;
    logic clk_prev_q;
    logic fall_w;

    ps2_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .RESET_LEVEL  (1'b1)
    ) u_clk_filt (
        .clk_i  (clk_100M),
        .rst_i  (reset),
        .pin_i  (ps2_clk),
        .level_o(clk_filt)
    );

    ps2_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .RESET_LEVEL  (1'b1)
    ) u_data_filt (
        .clk_i  (clk_100M),
        .rst_i  (reset),
        .pin_i  (ps2_data),
        .level_o(data_filt)
    );

    assign fall_w = clk_prev_q & ~clk_filt;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ps2_state_e    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          rx_done_q, rx_done_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          frame_error_q, frame_error_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bitcnt_d      = bitcnt_q;
        parity_d      = parity_q;
        timeout_d     = timeout_q;
        rx_done_d     = 1'b0;
        rx_byte_d     = rx_byte_q;
        frame_error_d = 1'b0;

        if (state_q == ST_IDLE) begin
            timeout_d = '0;
            if (fall_w && !data_filt) begin
                state_d  = ST_DATA;
                bitcnt_d = '0;
            end
        end else if (fall_w) begin
            timeout_d = '0;
            case (state_q)
                ST_DATA: begin
                    shift_d  = {data_filt, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_filt;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_filt && ps2_parity_ok(shift_q, parity_q)) begin
                        rx_done_d = 1'b1;
                        rx_byte_d = shift_q;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_q == TIMEOUT_LAST) begin
            // TIMEOUT_CYCLES cycles have elapsed since the last fall.
            state_d       = ST_IDLE;
            timeout_d     = '0;
            frame_error_d = 1'b1;
        end else begin
            timeout_d = timeout_q + TW'(1);
        end
    end

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            clk_prev_q    <= 1'b1;
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bitcnt_q      <= '0;
            parity_q      <= 1'b0;
            timeout_q     <= '0;
            rx_done_q     <= 1'b0;
            rx_byte_q     <= '0;
            frame_error_q <= 1'b0;
        end else begin
            clk_prev_q    <= clk_filt;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bitcnt_q      <= bitcnt_d;
            parity_q      <= parity_d;
            timeout_q     <= timeout_d;
            rx_done_q     <= rx_done_d;
            rx_byte_q     <= rx_byte_d;
            frame_error_q <= frame_error_d;
        end
    end

    // ------------------------------------------------------------------
    // Prefix decode and event FIFO
    // ------------------------------------------------------------------
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic          overflow_q, overflow_d;
    logic          push_w;
    logic          push_ok;
    logic          pop_w;
    logic          empty_w;
    logic          full_w;
    ps2_event_t    push_evt;
    ps2_event_t    head;
    ps2_event_t    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_w   = !empty_w && event_ready;

    always_comb begin
        ext_d    = ext_q;
        rel_d    = rel_q;
        push_w   = 1'b0;
        push_evt = '{extended: ext_q, released: rel_q, code: rx_byte_q};
        if (rx_done_q) begin
            if (rx_byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_PREFIX_REL) begin
                rel_d = 1'b1;
            end else begin
                push_w = 1'b1;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end
        end
        if (frame_error_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    // A full FIFO still accepts the push when the head is popped the same cycle.
    assign push_ok    = push_w && (!full_w || pop_w);
    assign overflow_d = push_w && full_w && !pop_w;
    assign wr_ptr_d   = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d   = pop_w   ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
            end
        end
    end

    assign head           = mem_q[rd_ptr_q[AW-1:0]];
    assign event_valid    = !empty_w;
    assign event_code     = head.code;
    assign event_extended = head.extended;
    assign event_release  = head.released;
    assign frame_error    = frame_error_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver with a frame-level reference model.
module tb_ps2_keyboard_receiver;

    localparam int unsigned FILT  = 8;
    localparam int unsigned TMO   = 600;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HALF  = 20;

    logic       clk_100M = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       event_ready = 1'b0;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_release;
    logic       frame_error;
    logic       overflow;

    ps2_keyboard_receiver #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_100M      (clk_100M),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_code    (event_code),
        .event_extended(event_extended),
        .event_release (event_release),
        .frame_error   (frame_error),
        .overflow      (overflow)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        int unsigned at;
        logic [7:0]  b;
    } pend_t;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned cyc    = 0;

    pend_t       pend_q[$];
    int unsigned err_at_q[$];
    logic [9:0]  mq[$];
    logic [7:0]  pop_log[$];
    bit          m_ext, m_rel, in_frame;
    int unsigned nbits, deadline;
    logic [9:0]  fbits;
    bit          exp_fe, exp_ov;

    int unsigned fe_count = 0;
    int unsigned ov_count = 0;
    int unsigned last_fall_drive = 0;
    int unsigned valid_rise_cyc  = 0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A pin change driven at cycle c shows up as a filtered fall pulse in
    // cycle c+FILT+2; the frame logic reacts to it one cycle later.
    task automatic model_fall(input logic d);
        int unsigned after_fall;
        pend_t p;
        last_fall_drive = cyc;
        after_fall = cyc + FILT + 3;
        if (!in_frame) begin
            if (!d) begin
                in_frame = 1'b1;
                nbits    = 0;
                deadline = after_fall + TMO;
            end
        end else begin
            fbits[nbits] = d;
            nbits++;
            if (nbits == 10) begin
                in_frame = 1'b0;
                if (fbits[9] && ($countones(fbits[8:0]) % 2 == 1)) begin
                    p.at = after_fall + 1;
                    p.b  = fbits[7:0];
                    pend_q.push_back(p);
                end else begin
                    err_at_q.push_back(after_fall);
                end
            end else begin
                deadline = after_fall + TMO;
            end
        end
    endtask

    always @(posedge clk_100M) begin
        logic [7:0] b;
        cyc++;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (reset) begin
            pend_q.delete();
            err_at_q.delete();
            mq.delete();
            m_ext    = 1'b0;
            m_rel    = 1'b0;
            in_frame = 1'b0;
        end else begin
            if (event_ready && mq.size() != 0) void'(mq.pop_front());
            if (err_at_q.size() != 0 && err_at_q[0] == cyc) begin
                void'(err_at_q.pop_front());
                exp_fe = 1'b1;
                m_ext  = 1'b0;
                m_rel  = 1'b0;
            end
            if (in_frame && cyc == deadline) begin
                in_frame = 1'b0;
                exp_fe   = 1'b1;
                m_ext    = 1'b0;
                m_rel    = 1'b0;
            end
            if (pend_q.size() != 0 && pend_q[0].at == cyc) begin
                b = pend_q[0].b;
                void'(pend_q.pop_front());
                if (b == 8'hE0) m_ext = 1'b1;
                else if (b == 8'hF0) m_rel = 1'b1;
                else begin
                    if (mq.size() >= DEPTH) exp_ov = 1'b1;
                    else mq.push_back({m_ext, m_rel, b});
                    m_ext = 1'b0;
                    m_rel = 1'b0;
                end
            end
        end
        if (event_valid && event_ready) pop_log.push_back(event_code);
    end

    always @(negedge clk_100M) begin
        chk("valid", {31'd0, event_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("code", {24'd0, event_code}, {24'd0, mq[0][7:0]});
            chk("ext",  {31'd0, event_extended}, {31'd0, mq[0][9]});
            chk("rel",  {31'd0, event_release},  {31'd0, mq[0][8]});
        end else if (reset) begin
            chk("rst_code", {24'd0, event_code}, 32'd0);
            chk("rst_flags", {30'd0, event_extended, event_release}, 32'd0);
        end
        chk("frame_error", {31'd0, frame_error}, {31'd0, exp_fe});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ov});
        if (frame_error) fe_count++;
        if (overflow) ov_count++;
        if (event_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = event_valid;
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk_100M);
        #1;
    endtask

    task automatic send_bit(input logic d);
        ps2_data = d;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        model_fall(d);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ flip_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int unsigned n);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) if (i < n) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic pop_one();
        event_ready = 1'b1;
        wait_cyc(1);
        event_ready = 1'b0;
        wait_cyc(1);
    endtask

    task automatic expect_head(input string name, input logic [7:0] code, input logic ext, input logic rel);
        chk({name, "_valid"}, {31'd0, event_valid}, 32'd1);
        chk({name, "_code"}, {24'd0, event_code}, {24'd0, code});
        chk({name, "_flags"}, {30'd0, event_extended, event_release}, {30'd0, ext, rel});
    endtask

    initial begin
        int unsigned fe0, ov0;
        logic [7:0] ovf_codes [5];
        ovf_codes[0] = 8'h16; ovf_codes[1] = 8'h1E; ovf_codes[2] = 8'h26;
        ovf_codes[3] = 8'h25; ovf_codes[4] = 8'h2E;

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        chk("reset_valid", {31'd0, event_valid}, 32'd0);
        chk("reset_err", {30'd0, frame_error, overflow}, 32'd0);

        send_frame(8'h1C, 1'b0);
        chk("latency", valid_rise_cyc - (last_fall_drive + FILT + 2), 32'd2);
        expect_head("f1c", 8'h1C, 1'b0, 1'b0);
        pop_one();
        chk("f1c_drained", {31'd0, event_valid}, 32'd0);

        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        expect_head("brk", 8'h1C, 1'b0, 1'b1);
        pop_one();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_head("extbrk", 8'h75, 1'b1, 1'b1);
        pop_one();
        send_frame(8'h1C, 1'b0);
        expect_head("plain", 8'h1C, 1'b0, 1'b0);
        pop_one();

        fe0 = fe_count;
        send_frame(8'h1C, 1'b1);
        chk("parity_err_pulses", fe_count - fe0, 32'd1);
        chk("parity_no_event", {31'd0, event_valid}, 32'd0);
        send_frame(8'h29, 1'b0);
        expect_head("after_par", 8'h29, 1'b0, 1'b0);
        pop_one();

        fe0 = fe_count;
        send_partial(8'h29, 4);
        wait_cyc(TMO + 60);
        chk("timeout_pulses", fe_count - fe0, 32'd1);
        send_frame(8'h29, 1'b0);
        expect_head("after_tmo", 8'h29, 1'b0, 1'b0);
        pop_one();

        ov0 = ov_count;
        for (int i = 0; i < 5; i++) send_frame(ovf_codes[i], 1'b0);
        chk("ovf_pulses", ov_count - ov0, 32'd1);
        pop_log.delete();
        event_ready = 1'b1;
        wait_cyc(10);
        event_ready = 1'b0;
        chk("ovf_pops", pop_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) chk("ovf_order", {24'd0, pop_log[i]}, {24'd0, ovf_codes[i]});
        end
        chk("ovf_drained", {31'd0, event_valid}, 32'd0);

        fe0 = fe_count;
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(TMO + 60);
        chk("glitch_err", fe_count - fe0, 32'd0);
        send_frame(8'h1C, 1'b0);
        expect_head("after_glitch", 8'h1C, 1'b0, 1'b0);
        pop_one();

        fe0 = fe_count;
        send_partial(8'h45, 3);
        reset = 1'b1;
        wait_cyc(5);
        chk("midrst_outs", {22'd0, event_valid, event_code, event_extended, event_release, frame_error, overflow}, 32'd0);
        reset = 1'b0;
        wait_cyc(TMO + 60);
        chk("midrst_err", fe_count - fe0, 32'd0);
        send_frame(8'h5A, 1'b0);
        expect_head("after_rst", 8'h5A, 1'b0, 1'b0);
        pop_one();

        wait_cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
